// File: rtl/imem_boot_arbiter_pkg.sv
// Shared types and default sizing for the instruction-memory boot arbiter.
package imem_pkg;

  localparam int IMEM_ADDR_W     = 11;
  localparam int IMEM_DATA_W     = 16;
  localparam int IMEM_RD_LAT_MAX = 3;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_boot_arbiter_rd_pipe.sv
// Read-valid delay line: a read strobe emerges DEPTH cycles later; flush empties it.
module imem_rd_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stage_r;

  // Shift the strobe one stage per cycle, zeroing every stage on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {DEPTH{1'b0}};
    end else if (flush) begin
      stage_r <= {DEPTH{1'b0}};
    end else begin
      stage_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out_valid = stage_r[DEPTH-1];

endmodule

// File: rtl/imem_boot_arbiter.sv
// Shares the single-port instruction BSRAM between the boot loader and CPU fetch.
// Optional load checksum is built when IMEM_CHECKSUM_EN is defined.
module imem_boot_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W       = IMEM_ADDR_W,
  parameter int DATA_W       = IMEM_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload_req,
  output logic              boot_mode,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic              mem_oce,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int RD_DEPTH = (READ_LATENCY > IMEM_RD_LAT_MAX) ? IMEM_RD_LAT_MAX :
                            ((READ_LATENCY < 1) ? 1 : READ_LATENCY);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  imem_state_e       state_r;
  imem_state_e       state_nxt_s;
  logic              accept_s;
  logic              reload_s;
  logic              rd_en_s;
  logic              rd_issue_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W:0]   load_count_r;
  logic              ld_ready_r;
  logic              boot_mode_r;
  logic              mem_ce_r;
  logic              mem_wre_r;
  logic [ADDR_W-1:0] mem_ad_r;
  logic [DATA_W-1:0] mem_din_r;

  // Next-state decode plus the per-cycle accept / reload / read strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    reload_s    = 1'b0;
    rd_en_s     = 1'b0;
    case (state_r)
      LOAD: begin
        accept_s = ld_valid & ld_ready_r;
        if (accept_s && (ld_last || (wr_addr_r == ADDR_LAST))) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (reload_req) begin
          reload_s    = 1'b1;
          state_nxt_s = LOAD;
        end else begin
          // The CPU is still held while boot_mode is visible, so its requests wait.
          rd_en_s     = cpu_req & ~boot_mode_r;
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = LOAD;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered handshake, mode flag and BSRAM port drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ready_r  <= 1'b0;
      boot_mode_r <= 1'b1;
      mem_ce_r    <= 1'b0;
      mem_wre_r   <= 1'b0;
      mem_ad_r    <= {ADDR_W{1'b0}};
      mem_din_r   <= {DATA_W{1'b0}};
    end else begin
      ld_ready_r  <= (state_nxt_s == LOAD);
      // Stays high through the first RUN cycle so the drained write settles first.
      boot_mode_r <= (state_r != RUN) || (state_nxt_s != RUN);
      mem_ce_r    <= accept_s | rd_en_s;
      mem_wre_r   <= accept_s;
      if (accept_s) begin
        mem_ad_r  <= wr_addr_r;
        mem_din_r <= ld_data;
      end else if (state_r == RUN) begin
        mem_ad_r  <= cpu_addr;
      end
    end
  end

  // Write pointer and word count for the current load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_r    <= {ADDR_W{1'b0}};
      load_count_r <= {(ADDR_W+1){1'b0}};
    end else if (reload_s) begin
      wr_addr_r    <= {ADDR_W{1'b0}};
      load_count_r <= {(ADDR_W+1){1'b0}};
    end else if (accept_s) begin
      wr_addr_r    <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      load_count_r <= load_count_r + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // Modulo-2^DATA_W running sum of accepted loader words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (reload_s) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      checksum_r <= checksum_r + ld_data;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = {DATA_W{1'b0}};
`endif

  assign rd_issue_s = mem_ce_r & ~mem_wre_r;

  imem_rd_pipe #(
    .DEPTH (RD_DEPTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (reload_s),
    .in_valid  (rd_issue_s),
    .out_valid (instr_valid)
  );

  assign ld_ready   = ld_ready_r;
  assign boot_mode  = boot_mode_r;
  assign load_count = load_count_r;
  assign mem_ce     = mem_ce_r;
  assign mem_wre    = mem_wre_r;
  assign mem_oce    = 1'b1;
  assign mem_ad     = mem_ad_r;
  assign mem_din    = mem_din_r;
  assign instr      = mem_dout;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Self-checking bench for imem_boot_arbiter: a full-size instance and a 16-word instance.
module tb_imem_boot_arbiter;

  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int RL  = 1;
  localparam int AW4 = 4;
`ifdef IMEM_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ld_valid, ld_last, ld_ready, reload_req, boot_mode, cpu_req, instr_valid;
  logic          mem_ce, mem_wre, mem_oce;
  logic [DW-1:0] ld_data, instr, checksum, mem_din, mem_dout;
  logic [AW-1:0] cpu_addr, mem_ad;
  logic [AW:0]   load_count;

  logic           ld_valid4, ld_last4, ld_ready4, reload_req4, boot_mode4, cpu_req4, instr_valid4;
  logic           mem_ce4, mem_wre4, mem_oce4;
  logic [DW-1:0]  ld_data4, instr4, checksum4, mem_din4;
  logic [DW-1:0]  mem_dout4;
  logic [AW4-1:0] cpu_addr4, mem_ad4;
  logic [AW4:0]   load_count4;

  imem_boot_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .reload_req(reload_req), .boot_mode(boot_mode), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .instr(instr), .instr_valid(instr_valid), .load_count(load_count),
    .checksum(checksum), .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_oce(mem_oce),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout));

  imem_boot_arbiter #(.ADDR_W(AW4), .DATA_W(DW), .READ_LATENCY(RL)) dut4 (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid4), .ld_data(ld_data4), .ld_last(ld_last4),
    .ld_ready(ld_ready4), .reload_req(reload_req4), .boot_mode(boot_mode4), .cpu_req(cpu_req4),
    .cpu_addr(cpu_addr4), .instr(instr4), .instr_valid(instr_valid4), .load_count(load_count4),
    .checksum(checksum4), .mem_ce(mem_ce4), .mem_wre(mem_wre4), .mem_oce(mem_oce4),
    .mem_ad(mem_ad4), .mem_din(mem_din4), .mem_dout(mem_dout4));

  // Behavioural BSRAM for the full-size instance, with a write log.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:RL-1];
  logic [AW-1:0] wlog_a[$];
  logic [DW-1:0] wlog_d[$];
  always @(posedge clk) begin
    if (mem_ce && mem_wre) begin
      ram[mem_ad] <= mem_din;
      wlog_a.push_back(mem_ad);
      wlog_d.push_back(mem_din);
    end
    if (mem_ce && !mem_wre) rpipe[0] <= ram[mem_ad];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_dout = rpipe[RL-1];

  // Write log for the small instance (its reads are never exercised).
  logic [AW4-1:0] wlog4_a[$];
  logic [DW-1:0]  wlog4_d[$];
  always @(posedge clk) begin
    if (mem_ce4 && mem_wre4) begin
      wlog4_a.push_back(mem_ad4);
      wlog4_d.push_back(mem_din4);
    end
  end
  assign mem_dout4 = 16'h0000;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          last;
    logic          e_ce;
    logic [AW-1:0] e_ad;
    logic          e_ready;
    logic          e_boot;
  } vec_t;

  vec_t          tbl [14];
  logic [DW-1:0] words [0:63];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] sum;
  bit            q_v[$];
  logic [AW-1:0] q_a[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload_req = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    ld_valid4 = 1'b0; ld_data4 = '0; ld_last4 = 1'b0; reload_req4 = 1'b0; cpu_req4 = 1'b0; cpu_addr4 = '0;

    // Gapped-load vectors: one word every 3 cycles, last on the 4th.
    for (int k = 0; k < 14; k++) begin
      tbl[k].v       = ((k % 3) == 0) && (k <= 9);
      tbl[k].d       = 16'hA000 + 16'(k / 3);
      tbl[k].last    = (k == 9);
      tbl[k].e_ce    = tbl[k].v;
      tbl[k].e_ad    = AW'(k / 3);
      tbl[k].e_ready = (k < 9);
      tbl[k].e_boot  = (k < 11);
    end

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_boot_mode", boot_mode, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_wre", mem_wre, 0);
    chk("rst_mem_ad", mem_ad, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_mem_oce", mem_oce, 1);
    rst_n = 1'b1;
    tick();
    chk("ld_ready_rise", ld_ready, 1);

    // Gapped load through the vector table.
    for (int k = 0; k < 14; k++) begin
      ld_valid = tbl[k].v;
      ld_data  = tbl[k].d;
      ld_last  = tbl[k].last;
      tick();
      chk($sformatf("gap_ce[%0d]", k), mem_ce, tbl[k].e_ce);
      chk($sformatf("gap_wre[%0d]", k), mem_wre, tbl[k].e_ce);
      chk($sformatf("gap_ready[%0d]", k), ld_ready, tbl[k].e_ready);
      chk($sformatf("gap_boot[%0d]", k), boot_mode, tbl[k].e_boot);
      if (tbl[k].e_ce) begin
        chk($sformatf("gap_ad[%0d]", k), mem_ad, tbl[k].e_ad);
        chk($sformatf("gap_din[%0d]", k), mem_din, tbl[k].d);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("gap_count", load_count, 4);
    chk("gap_nwrites", wlog_a.size(), 4);

    // Single fetch of address 2.
    cpu_req = 1'b1; cpu_addr = 11'd2;
    tick();
    cpu_req = 1'b0;
    chk("rd_early", instr_valid, 0);
    tick();
    chk("rd_valid", instr_valid, 1);
    chk("rd_instr", instr, 16'hA002);
    tick();
    chk("rd_done", instr_valid, 0);

    // Reload while a fetch is in flight.
    cpu_req = 1'b1; cpu_addr = 11'd1;
    tick();
    cpu_req = 1'b0; reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    chk("rl_flush", instr_valid, 0);
    chk("rl_boot", boot_mode, 1);
    chk("rl_ready", ld_ready, 1);
    chk("rl_count", load_count, 0);
    chk("rl_checksum", checksum, 0);

    // 18 back-to-back words.
    wlog_a.delete(); wlog_d.delete();
    sum = 16'h0000;
    for (int i = 0; i < 18; i++) begin
      words[i] = 16'($urandom);
      sum      = sum + words[i];
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 17);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("b2b_boot_n0", boot_mode, 1);
    tick();
    chk("b2b_boot_n1", boot_mode, 1);
    tick();
    chk("b2b_boot_n2", boot_mode, 0);
    chk("b2b_count", load_count, 18);
    chk("b2b_checksum", checksum, CSUM_ON ? sum : 16'h0000);
    chk("b2b_nwrites", wlog_a.size(), 18);
    for (int i = 0; i < 18 && i < wlog_a.size(); i++) begin
      chk($sformatf("b2b_wad[%0d]", i), wlog_a[i], i);
      chk($sformatf("b2b_wdat[%0d]", i), wlog_d[i], words[i]);
    end
    cpu_req = 1'b1; cpu_addr = 11'd5;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("b2b_rd5_valid", instr_valid, 1);
    chk("b2b_rd5_instr", instr, words[5]);

    // Randomized loads and fetches against the reference model.
    for (int r = 0; r < 4; r++) begin
      int n, i, cyc;
      reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
      n = $urandom_range(1, 30);
      i = 0; cyc = 0; sum = 16'h0000;
      while (i < n && cyc < 400) begin
        logic v;
        logic [DW-1:0] d;
        v = 1'($urandom_range(0, 1));
        d = 16'($urandom);
        ld_valid = v; ld_data = d; ld_last = (i == n - 1);
        cpu_req = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom);
        reload_req = ($urandom_range(0, 7) == 0);
        tick();
        chk("rnd_load_novalid", instr_valid, 0);
        if (v) begin
          model_mem[i] = d;
          sum = sum + d;
          i++;
        end
        cyc++;
      end
      ld_valid = 1'b0; ld_last = 1'b0; cpu_req = 1'b0; reload_req = 1'b0;
      chk("rnd_load_budget", (cyc < 400), 1);
      for (int c = 0; c < 10 && boot_mode; c++) tick();
      chk("rnd_boot_fall", boot_mode, 0);
      chk("rnd_count", load_count, n);
      chk("rnd_checksum", checksum, CSUM_ON ? sum : 16'h0000);
      q_v.delete(); q_a.delete();
      for (int k = 0; k < RL; k++) begin
        q_v.push_back(1'b0);
        q_a.push_back('0);
      end
      for (int c = 0; c < 40; c++) begin
        bit ev;
        logic [AW-1:0] ea;
        cpu_req = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, n - 1));
        tick();
        ev = q_v.pop_front();
        ea = q_a.pop_front();
        q_v.push_back(cpu_req);
        q_a.push_back(cpu_addr);
        chk("rnd_rd_valid", instr_valid, ev);
        if (ev) chk("rnd_rd_instr", instr, model_mem[ea]);
      end
      cpu_req = 1'b0;
      tick();
    end

    // Small instance: 17 words with no ld_last must stop at 16.
    for (int i = 0; i < 17; i++) begin
      ld_valid4 = 1'b1; ld_data4 = 16'h4000 + 16'(i); ld_last4 = 1'b0;
      tick();
    end
    chk("full_ready_low", ld_ready4, 0);
    ld_valid4 = 1'b0;
    for (int c = 0; c < 10 && boot_mode4; c++) tick();
    chk("full_boot_fall", boot_mode4, 0);
    chk("full_count", load_count4, 16);
    chk("full_nwrites", wlog4_a.size(), 16);
    for (int i = 0; i < wlog4_a.size(); i++) begin
      chk($sformatf("full_wad[%0d]", i), wlog4_a[i], i);
      chk($sformatf("full_wdat[%0d]", i), wlog4_d[i], 16'h4000 + 16'(i));
    end

    // Checksum wrap on the small instance.
    reload_req4 = 1'b1;
    tick();
    reload_req4 = 1'b0;
    ld_valid4 = 1'b1; ld_data4 = 16'hFFFF;
    tick();
    ld_data4 = 16'h0002; ld_last4 = 1'b1;
    tick();
    ld_valid4 = 1'b0; ld_last4 = 1'b0;
    chk("csum_value", checksum4, CSUM_ON ? 16'h0001 : 16'h0000);
    chk("csum_count", load_count4, 2);

    // Reset in the middle of a load restarts at address 0.
    reload_req = 1'b1;
    tick();
    reload_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'h7000 + 16'(i);
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_count", load_count, 0);
    chk("mid_rst_boot", boot_mode, 1);
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_ce", mem_ce, 0);
    rst_n = 1'b1;
    wlog_a.delete(); wlog_d.delete();
    tick();
    ld_valid = 1'b1; ld_data = 16'h5A5A; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    chk("mid_rst_nwrites", wlog_a.size(), 1);
    if (wlog_a.size() > 0) chk("mid_rst_wad", wlog_a[0], 0);
    chk("mid_rst_count2", load_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_arbiter.md
# imem_boot_arbiter

Owns the single-port instruction BSRAM (Gowin_SP) and shares it between two requesters: a program loader streaming words in, and the CPU fetching by PC. After reset it is in boot mode, writing loader words to consecutive addresses. On the last word it drains the final write and hands the memory port to the CPU. It replaces ad-hoc boot sequencing at the top level and supports a runtime reload.

## Interface
- ADDR_W, 11: BSRAM address width.
- DATA_W, 16: instruction width.
- READ_LATENCY, 1: BSRAM read latency in cycles (1..3). This is the cycles from `mem_ce` with `mem_wre`=0 to valid `mem_dout`.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  marks final word of the program.
- ld_ready  out  1  arbiter accepts loader word this cycle.
- reload_req  in  1  single-cycle pulse; re-enter boot mode from RUN.
- boot_mode  out  1  high in LOAD/DRAIN; CPU must hold in reset/stall.
- cpu_req  in  1  fetch request at cpu_addr.
- cpu_addr  in  ADDR_W  CPU PC.
- instr  out  DATA_W  fetched instruction (mem_dout pass-through).
- instr_valid  out  1  instr corresponds to the request issued READ_LATENCY cycles earlier.
- load_count  out  ADDR_W+1  words written in the current/last load.
- checksum  out  DATA_W  load checksum (see Configuration).
- mem_ce, mem_wre, mem_oce  out  1  BSRAM controls; mem_oce tied 1.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_dout  in  DATA_W  BSRAM read data.

## Operation
- FSM states: LOAD, DRAIN, RUN. Reset state is LOAD.
- LOAD:
  - ld_ready=1.
  - Handshake accept = ld_valid & ld_ready. An accepted word is registered.
  - The cycle after acceptance drives mem_ce=1, mem_wre=1, mem_ad=wr_addr, mem_din=word. wr_addr then increments.
  - Throughput is one word per cycle.
- LOAD → DRAIN: on accept with ld_last=1, or on accept when wr_addr == 2^ADDR_W−1 (full; the word is written, no wrap).
- DRAIN:
  - ld_ready=0.
  - The pending write issues.
  - Next cycle → RUN.
- RUN:
  - boot_mode=0, ld_ready=0.
  - mem_ad=cpu_addr, mem_ce=cpu_req, mem_wre=0.
  - instr_valid = cpu_req delayed READ_LATENCY cycles.
- RUN → LOAD on reload_req:
  - wr_addr, load_count and checksum are cleared.
  - The instr_valid pipeline is flushed (zeroed) in the same cycle.
  - reload_req in LOAD or DRAIN is ignored.
- cpu_req in LOAD/DRAIN is ignored; instr_valid stays 0.
- ld_valid outside LOAD is not accepted.
- load_count = number of words written. Width ADDR_W+1 so a full 2^ADDR_W load is representable.
- Reset mid-load: all state returns to reset values. BSRAM contents are not cleared; the load restarts at address 0.

## Timing
- Reset values:
  - boot_mode=1, ld_ready=0, mem_ce=0, mem_wre=0, mem_ad=0, mem_din=0.
  - instr_valid=0, load_count=0, checksum=0.
  - ld_ready rises on the first clk edge after rst_n deasserts.
- Write latency: word accepted at edge N is written at edge N+1.
- Handover latency: last accept at edge N; DRAIN during N..N+1; boot_mode falls after edge N+2. The first CPU request can be issued in the cycle following edge N+2.
- Read latency: cpu_req at edge M gives instr_valid=1 and instr valid in the cycle after edge M+READ_LATENCY.
- instr_valid is registered. instr is combinational from mem_dout.

## Configuration
- IMEM_CHECKSUM_EN defined: checksum accumulates the modulo-2^DATA_W sum of every accepted word. It is updated on accept, cleared on reset and on reload_req.
- Not defined: checksum is tied to 0 and no adder is synthesized. The port remains.

## Structure
- Package imem_pkg holds:
  - state enum `imem_state_e` {LOAD, DRAIN, RUN};
  - default ADDR_W/DATA_W constants;
  - the READ_LATENCY upper bound.
- Sub-module imem_rd_pipe: a READ_LATENCY-deep valid shift register with a synchronous flush input. It produces instr_valid.

## Test plan
- Load 18 words back-to-back (ld_last on word 17), then read: load_count=18. BSRAM addresses 0..17 hold the words. boot_mode falls 2 cycles after the last accept.
- Gapped ld_valid (one word every 3 cycles, 4 words): each write occurs exactly 1 cycle after its accept, addresses 0..3, no extra writes.
- RUN, cpu_req with cpu_addr=5 at cycle M (READ_LATENCY=1): instr_valid=1 in the cycle after M+1 and instr = word 5.
- reload_req while fetch in flight: instr_valid=0 next cycle, boot_mode=1, ld_ready=1, and the next word is written to address 0.
- With ADDR_W=4, stream 17 words without ld_last: 16 are written, the FSM reaches RUN, load_count=16, and the 17th word is not accepted.
- IMEM_CHECKSUM_EN, load words 0xFFFF, 0x0002: checksum=0x0001. Without the macro, checksum=0.
